op_encoder: RTL
===============

# op_encoder

Instruction encoder and fetch-bundle packer: the inverse of the front-end `istable` decode. It accepts one structured micro-op request per cycle (`opcode_t` plus register and immediate operands) and encodes it into a 32-bit A64 word. It packs the words into `SUPER_SCALAR_WIDTH`-wide bundles and presents them on a valid/ready port. It sits in the test/boot path, generating programs directly into instruction memory or the fetch queue.

## Interface
- `SUPER_SCALAR_WIDTH`, 2: words per output bundle (from `op_pkg`).
- `INSTRUCTION_WIDTH`, 32: encoded word width (from `op_pkg`).
- `clk_in` in 1: clock.
- `rst_N_in` in 1: reset, asynchronous, active-low.
- `req_valid_in` in 1: request valid.
- `req_ready_out` out 1: request accepted on a rising edge when high together with `req_valid_in`.
- `req_opcode_in` in 7: `opcode_t`.
- `req_rd_in`, `req_rn_in`, `req_rm_in` in 5 each: register fields.
- `req_imm_in` in 64: immediate, branch offset in words, shift amount, or 64-bit constant.
- `req_hw_in` in 2: MOVZ/MOVK halfword select.
- `req_cond_in` in 4: B.cond condition.
- `req_mov64_in` in 1: expand into a 64-bit constant load (only when `OP_ENC_MOV64_EN` is defined).
- `flush_in` in 1: emit a partial bundle.
- `bundle_valid_out` out 1: bundle valid.
- `bundle_ready_in` in 1: bundle consumed.
- `bundle_out` out 2x32: `instruction_array`.
- `bundle_mask_out` out 2: per-slot valid; bit0 is the oldest word.
- `err_out` out 1: one-cycle pulse when an unencodable request is accepted.

## Operation
- Encoding, all 64-bit forms:
  - LDUR/STUR/F_LDUR/F_STUR: 11-bit prefix, imm9 in [20:12], rn, rt=rd.
  - MOVZ 0xD2800000, MOVK 0xF2800000: hw in [22:21], imm16 in [20:5].
  - ADRP 0x90000000: immlo in [30:29], immhi in [23:5].
  - ADD 0x91000000, SUB 0xD1000000: imm12 in [21:10].
  - ADDS 0xAB000000, SUBS 0xEB000000, ORR 0xAA000000, EOR 0xCA000000, ANDS 0xEA000000: rm, imm6=0.
  - CMN, CMP, TST: the corresponding base opcode with rd forced to 31.
  - MVN 0xAA200000 with rn=31.
  - LSL #s: 0xD3400000, immr=(64-s)&63, imms=63-s.
  - LSR #s: 0xD3400000, immr=s, imms=63.
  - ASR #s: 0x93400000, immr=s, imms=63.
  - UBFM: imm[11:6]=immr, imm[5:0]=imms.
  - B 0x14000000, BL 0x94000000: imm26.
  - B_COND 0x54000000: imm19 in [23:5], cond in [3:0].
  - RET 0xD65F0000 with rn (normally 30). NOP 0xD503201F. HLT 0xD4400000 with imm16 in [20:5].
  - FMOV 0x1E604000, FNEG 0x1E614000, FADD 0x1E602800, FSUB 0x1E603800, FMUL 0x1E600800, FCMPR 0x1E602000, FCMPI 0x1E602008.
- Immediates are truncated to field width; no range checking is done.
- OPCODE_ERROR or an out-of-range opcode: encodes 0x00000000 (UDF), pulses `err_out`, and the word is still packed.
- Packer: slot register plus count 0..2; an accepted word writes `slot[count]`.
- Transfer from packer to the output register happens when (count==2, or `flush_in` with count>0) and (`!bundle_valid_out` or `bundle_ready_in`).
  - On transfer: mask = filled slots; empty slots carry NOP; count→0 in the same edge.
- `req_ready_out` = !expanding && (count<2 || transfer this cycle).
- Flush with count==0: no effect. A flush in the same cycle a word is accepted applies to the next cycle.
- Reset (any time, including mid-expansion): count=0, FSM IDLE, all outputs 0.

## Timing
- Reset values: `req_ready_out`=1 after reset release, `bundle_valid_out`=0, `bundle_mask_out`=0, `bundle_out`=0, `err_out`=0.
- Encode latency: the word is in the slot at the accepting edge.
- The transfer edge is the edge after count reaches 2, and `bundle_valid_out` rises after that edge.
- Back-to-back full bundles sustain 1 word/cycle while `bundle_ready_in` is held high.
- The bundle holds stable while valid && !ready.

## Configuration
- `OP_ENC_MOV64_EN` defined:
  - `req_mov64_in` with MOVZ starts FSM IDLE→HW1→HW2→HW3→IDLE.
  - Emits MOVZ hw0, then MOVK hw1..hw3 with imm[63:48]-style slices, one word per cycle while packer space allows.
  - `req_ready_out` is low during HW1..HW3.
- Undefined: `req_mov64_in` is ignored; there is no FSM and each request produces one word.

## Structure
- Shared `op_pkg` additions: the base-opcode localparams listed above, NOP_WORD, and an `encode_fn(opcode_t, fields)` automatic function, kept next to `istable` so that `istable(encode_fn(x))==x` can be checked.
- One sub-module, `op_bundle_packer` (slots, count, output register, handshake); the top holds encode and the expansion FSM.

## Test plan
- ADD X1,X2,#5 then NOP, ready held high → one bundle {0x91001441, 0xD503201F}, mask 2'b11, valid two cycles after the first accept.
- CMP X4,X5 then flush → bundle {0xEB05009F, NOP}, mask 2'b01.
- Hold `bundle_ready_in`=0 for 5 cycles with a continuous request stream → `req_ready_out` drops after 4 words, bundle stable, no word lost or duplicated.
- OPCODE_ERROR request → word 0x00000000, `err_out` high exactly one cycle.
- Macro on, MOV64 X3=0x1122334455667788 → 0xD28EF103, 0xF2AAACC3, …, four words across two bundles. Macro off → a single MOVZ.
- Assert `rst_N_in` mid-expansion, asynchronously between edges → `bundle_valid_out`=0 immediately, no residual words after release.
- Round-trip sweep: `istable(bundle word)` equals the requested opcode for every opcode.

Source files
------------

// File: rtl/op_pkg.sv
// ============================================================================
// Module      : op_pkg
// Description : Shared opcode set, A64 base words and the encode_fn helper
//               used by the op_encoder packer path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package op_pkg;

    localparam int SUPER_SCALAR_WIDTH = 2;
    localparam int INSTRUCTION_WIDTH  = 32;

    typedef logic [INSTRUCTION_WIDTH-1:0] instruction_t;

    typedef enum logic [6:0] {
        OPCODE_ERROR = 7'd0,
        LDUR, STUR, F_LDUR, F_STUR, MOVZ, MOVK, ADRP, ADD, SUB,
        ADDS, SUBS, ORR, EOR, ANDS, CMN, CMP, TST, MVN,
        LSL, LSR, ASR, UBFM, B, BL, B_COND, RET, NOP, HLT,
        FMOV, FNEG, FADD, FSUB, FMUL, FCMPR, FCMPI,
        OPCODE_COUNT
    } opcode_t;

    typedef enum logic [1:0] {
        MV_IDLE = 2'd0,
        MV_HW1  = 2'd1,
        MV_HW2  = 2'd2,
        MV_HW3  = 2'd3
    } mov_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] imm;
        logic [1:0]  hw;
        logic [3:0]  cond;
    } enc_fields_t;

    localparam instruction_t ENC_LDUR   = 32'hF840_0000;
    localparam instruction_t ENC_STUR   = 32'hF800_0000;
    localparam instruction_t ENC_F_LDUR = 32'hFC40_0000;
    localparam instruction_t ENC_F_STUR = 32'hFC00_0000;
    localparam instruction_t ENC_MOVZ   = 32'hD280_0000;
    localparam instruction_t ENC_MOVK   = 32'hF280_0000;
    localparam instruction_t ENC_ADRP   = 32'h9000_0000;
    localparam instruction_t ENC_ADD    = 32'h9100_0000;
    localparam instruction_t ENC_SUB    = 32'hD100_0000;
    localparam instruction_t ENC_ADDS   = 32'hAB00_0000;
    localparam instruction_t ENC_SUBS   = 32'hEB00_0000;
    localparam instruction_t ENC_ORR    = 32'hAA00_0000;
    localparam instruction_t ENC_EOR    = 32'hCA00_0000;
    localparam instruction_t ENC_ANDS   = 32'hEA00_0000;
    localparam instruction_t ENC_MVN    = 32'hAA20_0000;
    localparam instruction_t ENC_UBFM   = 32'hD340_0000;
    localparam instruction_t ENC_SBFM   = 32'h9340_0000;
    localparam instruction_t ENC_B      = 32'h1400_0000;
    localparam instruction_t ENC_BL     = 32'h9400_0000;
    localparam instruction_t ENC_B_COND = 32'h5400_0000;
    localparam instruction_t ENC_RET    = 32'hD65F_0000;
    localparam instruction_t ENC_HLT    = 32'hD440_0000;
    localparam instruction_t ENC_FMOV   = 32'h1E60_4000;
    localparam instruction_t ENC_FNEG   = 32'h1E61_4000;
    localparam instruction_t ENC_FADD   = 32'h1E60_2800;
    localparam instruction_t ENC_FSUB   = 32'h1E60_3800;
    localparam instruction_t ENC_FMUL   = 32'h1E60_0800;
    localparam instruction_t ENC_FCMPR  = 32'h1E60_2000;
    localparam instruction_t ENC_FCMPI  = 32'h1E60_2008;
    localparam instruction_t NOP_WORD   = 32'hD503_201F;

    function automatic logic op_is_error(input logic [6:0] op);
        return (op == OPCODE_ERROR) || (op >= OPCODE_COUNT);
    endfunction

    // Immediates are silently truncated to each field; unknown opcodes give UDF (all zero).
    function automatic instruction_t encode_fn(input opcode_t op, input enc_fields_t f);
        logic [5:0]   s;
        instruction_t w;
        s = f.imm[5:0];
        case (op)
            LDUR:   w = ENC_LDUR   | {11'b0, f.imm[8:0], 2'b0, f.rn, f.rd};
            STUR:   w = ENC_STUR   | {11'b0, f.imm[8:0], 2'b0, f.rn, f.rd};
            F_LDUR: w = ENC_F_LDUR | {11'b0, f.imm[8:0], 2'b0, f.rn, f.rd};
            F_STUR: w = ENC_F_STUR | {11'b0, f.imm[8:0], 2'b0, f.rn, f.rd};
            MOVZ:   w = ENC_MOVZ   | {9'b0, f.hw, f.imm[15:0], f.rd};
            MOVK:   w = ENC_MOVK   | {9'b0, f.hw, f.imm[15:0], f.rd};
            ADRP:   w = ENC_ADRP   | {1'b0, f.imm[1:0], 5'b0, f.imm[20:2], f.rd};
            ADD:    w = ENC_ADD    | {10'b0, f.imm[11:0], f.rn, f.rd};
            SUB:    w = ENC_SUB    | {10'b0, f.imm[11:0], f.rn, f.rd};
            ADDS:   w = ENC_ADDS   | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            SUBS:   w = ENC_SUBS   | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            ORR:    w = ENC_ORR    | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            EOR:    w = ENC_EOR    | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            ANDS:   w = ENC_ANDS   | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            CMN:    w = ENC_ADDS   | {11'b0, f.rm, 6'b0, f.rn, 5'd31};
            CMP:    w = ENC_SUBS   | {11'b0, f.rm, 6'b0, f.rn, 5'd31};
            TST:    w = ENC_ANDS   | {11'b0, f.rm, 6'b0, f.rn, 5'd31};
            MVN:    w = ENC_MVN    | {11'b0, f.rm, 6'b0, 5'd31, f.rd};
            LSL:    w = ENC_UBFM   | {10'b0, 6'd0 - s, 6'd63 - s, f.rn, f.rd};
            LSR:    w = ENC_UBFM   | {10'b0, s, 6'd63, f.rn, f.rd};
            ASR:    w = ENC_SBFM   | {10'b0, s, 6'd63, f.rn, f.rd};
            UBFM:   w = ENC_UBFM   | {10'b0, f.imm[11:6], f.imm[5:0], f.rn, f.rd};
            B:      w = ENC_B      | {6'b0, f.imm[25:0]};
            BL:     w = ENC_BL     | {6'b0, f.imm[25:0]};
            B_COND: w = ENC_B_COND | {8'b0, f.imm[18:0], 1'b0, f.cond};
            RET:    w = ENC_RET    | {22'b0, f.rn, 5'b0};
            NOP:    w = NOP_WORD;
            HLT:    w = ENC_HLT    | {11'b0, f.imm[15:0], 5'b0};
            FMOV:   w = ENC_FMOV   | {22'b0, f.rn, f.rd};
            FNEG:   w = ENC_FNEG   | {22'b0, f.rn, f.rd};
            FADD:   w = ENC_FADD   | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            FSUB:   w = ENC_FSUB   | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            FMUL:   w = ENC_FMUL   | {11'b0, f.rm, 6'b0, f.rn, f.rd};
            FCMPR:  w = ENC_FCMPR  | {11'b0, f.rm, 6'b0, f.rn, 5'b0};
            FCMPI:  w = ENC_FCMPI  | {22'b0, f.rn, 5'b0};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/op_bundle_packer.sv
// ============================================================================
// Module      : op_bundle_packer
// Description : Collects encoded words into slots and hands full (or flushed)
//               bundles to a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_bundle_packer
    import op_pkg::*;
#(
    parameter int SSW = SUPER_SCALAR_WIDTH,
    parameter int IW  = INSTRUCTION_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              word_valid_i,
    input  logic [IW-1:0]     word_i,
    output logic              word_ready_o,
    input  logic              flush_i,
    output logic              bundle_valid_o,
    input  logic              bundle_ready_i,
    output logic [SSW*IW-1:0] bundle_o,
    output logic [SSW-1:0]    mask_o
);

    localparam int CW = $clog2(SSW + 1);

    logic [IW-1:0]     slot_q [SSW];
    logic [CW-1:0]     count_q;
    logic              valid_q;
    logic [SSW*IW-1:0] bundle_q;
    logic [SSW-1:0]    mask_q;

    logic              w_full;
    logic              w_transfer;
    logic              w_accept;
    logic [CW-1:0]     w_wr_idx;
    logic [SSW*IW-1:0] w_next_bundle;
    logic [SSW-1:0]    w_next_mask;

    assign w_full       = (count_q == CW'(SSW));
    assign w_transfer   = (w_full || (flush_i && (count_q != '0))) && (!valid_q || bundle_ready_i);
    assign word_ready_o = !w_full || w_transfer;
    assign w_accept     = word_valid_i && word_ready_o;
    // A word accepted on a transfer edge lands in slot 0 of the fresh bundle.
    assign w_wr_idx     = w_transfer ? '0 : count_q;

    always_comb begin
        w_next_bundle = '0;
        w_next_mask   = '0;
        for (int i = 0; i < SSW; i++) begin
            w_next_mask[i]            = (CW'(i) < count_q);
            w_next_bundle[i*IW +: IW] = w_next_mask[i] ? slot_q[i] : NOP_WORD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            valid_q  <= 1'b0;
            bundle_q <= '0;
            mask_q   <= '0;
            for (int i = 0; i < SSW; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (w_transfer) begin
                bundle_q <= w_next_bundle;
                mask_q   <= w_next_mask;
                valid_q  <= 1'b1;
            end else if (bundle_ready_i) begin
                valid_q  <= 1'b0;
            end
            for (int i = 0; i < SSW; i++) begin
                if (w_accept && (w_wr_idx == CW'(i))) begin
                    slot_q[i] <= word_i;
                end
            end
            count_q <= (w_transfer ? '0 : count_q) + CW'(w_accept);
        end
    end

    assign bundle_valid_o = valid_q;
    assign bundle_o       = bundle_q;
    assign mask_o         = mask_q;

endmodule

`default_nettype wire

// File: rtl/op_encoder.sv
// ============================================================================
// Module      : op_encoder
// Description : Encodes micro-op requests into A64 words and packs them into
//               fetch bundles. Define OP_ENC_MOV64_EN to enable the 64-bit
//               constant expansion (MOVZ + 3x MOVK).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_encoder
    import op_pkg::*;
(
    input  logic                                          clk_in,
    input  logic                                          rst_N_in,
    input  logic                                          req_valid_in,
    output logic                                          req_ready_out,
    input  logic [6:0]                                    req_opcode_in,
    input  logic [4:0]                                    req_rd_in,
    input  logic [4:0]                                    req_rn_in,
    input  logic [4:0]                                    req_rm_in,
    input  logic [63:0]                                   req_imm_in,
    input  logic [1:0]                                    req_hw_in,
    input  logic [3:0]                                    req_cond_in,
    input  logic                                          req_mov64_in,
    input  logic                                          flush_in,
    output logic                                          bundle_valid_out,
    input  logic                                          bundle_ready_in,
    output logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] bundle_out,
    output logic [SUPER_SCALAR_WIDTH-1:0]                 bundle_mask_out,
    output logic                                          err_out
);

    enc_fields_t  w_fields;
    opcode_t      w_op;
    logic         w_word_valid;
    instruction_t w_word;
    logic         w_pk_ready;
    logic         w_req_ready;
    logic         err_q;

    assign w_op     = opcode_t'(req_opcode_in);
    assign w_fields = '{rd: req_rd_in, rn: req_rn_in, rm: req_rm_in,
                        imm: req_imm_in, hw: req_hw_in, cond: req_cond_in};

`ifdef OP_ENC_MOV64_EN
    mov_state_t  state_q, state_d;
    logic [63:0] imm_q;
    logic [4:0]  rd_q;
    enc_fields_t w_movz_f;

    always_comb begin
        state_d      = state_q;
        w_word_valid = req_valid_in;
        w_word       = encode_fn(w_op, w_fields);
        w_req_ready  = w_pk_ready;
        w_movz_f     = w_fields;
        w_movz_f.hw  = 2'd0;
        case (state_q)
            MV_IDLE: begin
                if (req_valid_in && w_pk_ready && req_mov64_in && (w_op == MOVZ)) begin
                    w_word  = encode_fn(MOVZ, w_movz_f);
                    state_d = MV_HW1;
                end
            end
            MV_HW1: begin
                w_req_ready  = 1'b0;
                w_word_valid = 1'b1;
                w_word       = ENC_MOVK | {9'b0, 2'd1, imm_q[31:16], rd_q};
                if (w_pk_ready) state_d = MV_HW2;
            end
            MV_HW2: begin
                w_req_ready  = 1'b0;
                w_word_valid = 1'b1;
                w_word       = ENC_MOVK | {9'b0, 2'd2, imm_q[47:32], rd_q};
                if (w_pk_ready) state_d = MV_HW3;
            end
            default: begin
                w_req_ready  = 1'b0;
                w_word_valid = 1'b1;
                w_word       = ENC_MOVK | {9'b0, 2'd3, imm_q[63:48], rd_q};
                if (w_pk_ready) state_d = MV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q <= MV_IDLE;
            imm_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == MV_IDLE) && (state_d == MV_HW1)) begin
                imm_q <= req_imm_in;
                rd_q  <= req_rd_in;
            end
        end
    end
`else
    logic w_unused_mov64;

    assign w_word_valid   = req_valid_in;
    assign w_word         = encode_fn(w_op, w_fields);
    assign w_req_ready    = w_pk_ready;
    assign w_unused_mov64 = req_mov64_in;
`endif

    op_bundle_packer u_packer (
        .clk_i          (clk_in),
        .rst_ni         (rst_N_in),
        .word_valid_i   (w_word_valid),
        .word_i         (w_word),
        .word_ready_o   (w_pk_ready),
        .flush_i        (flush_in),
        .bundle_valid_o (bundle_valid_out),
        .bundle_ready_i (bundle_ready_in),
        .bundle_o       (bundle_out),
        .mask_o         (bundle_mask_out)
    );

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req_valid_in && w_req_ready && op_is_error(req_opcode_in);
        end
    end

    assign req_ready_out = w_req_ready;
    assign err_out       = err_q;

endmodule

`default_nettype wire
